// File: rtl/serial_addsub_pkg.sv
// Shared types and constant helpers for the digit-serial adder/subtractor.
// Saturation constants are generated up to SAT_W bits of operand width.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int SAT_W = 64;

    // Step counter width; a single-step configuration still needs one bit.
    function automatic int cnt_width(input int nstep);
        return (nstep <= 1) ? 1 : $clog2(nstep);
    endfunction

    function automatic logic [SAT_W-1:0] sat_max(input int width);
        return (SAT_W'(1) << (width - 1)) - SAT_W'(1);
    endfunction

    function automatic logic [SAT_W-1:0] sat_min(input int width);
        return SAT_W'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/serial_addsub_digit.sv
// Combinational DIGIT-bit ripple adder built from chained full adders.
// c_msb is the carry into the top bit, used for signed overflow on the last step.
module ripple_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/sub, DIGIT bits per clock; SERIAL_ADDSUB_SAT_EN saturates sum on overflow.
// Latency: out_valid high NSTEP edges after acceptance; NSTEP+2 cycles per op minimum.
// Backpressure: result held in DONE while out_ready=0; in_valid ignored outside IDLE.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $fatal(1, "serial_addsub: WIDTH must be a positive multiple of DIGIT");
    end

    localparam int NSTEP = WIDTH / DIGIT;
    localparam int CW = cnt_width(NSTEP);
    localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

`ifdef SERIAL_ADDSUB_SAT_EN
    localparam logic [SAT_W-1:0] SAT_MAX_W = sat_max(WIDTH);
    localparam logic [SAT_W-1:0] SAT_MIN_W = sat_min(WIDTH);
    localparam logic [WIDTH-1:0] SAT_MAX = SAT_MAX_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_MIN = SAT_MIN_W[WIDTH-1:0];
`endif

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_shift;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             asign;
    logic [DIGIT-1:0] d_s;
    logic             d_co;
    logic             d_c_msb;

    ripple_digit #(.DIGIT(DIGIT)) u_digit (
        .x     (a_sr[DIGIT-1:0]),
        .y     (b_sr[DIGIT-1:0]),
        .ci    (carry),
        .s     (d_s),
        .co    (d_co),
        .c_msb (d_c_msb)
    );

    // New digit enters at the MSB end so the LSB digit lands at bit 0 after NSTEP steps.
    assign res_shift = (res >> DIGIT) | (WIDTH'(d_s) << (WIDTH - DIGIT));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            asign <= 1'b0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        asign <= a[WIDTH-1];
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> DIGIT;
                    b_sr  <= b_sr >> DIGIT;
                    carry <= d_co;
                    cnt   <= cnt + 1'b1;
                    res   <= res_shift;
                    if (cnt == LAST) begin
                        cout  <= d_co;
                        ovf   <= d_c_msb ^ d_co;
                        state <= DONE;
`ifdef SERIAL_ADDSUB_SAT_EN
                        // Overflow direction follows a's sign: a positive a can only overflow upward.
                        if (d_c_msb ^ d_co) begin
                            res <= asign ? SAT_MIN : SAT_MAX;
                        end
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and randomized checks of serial_addsub (WIDTH=16, DIGIT=4) against an arithmetic model.
module tb_serial_addsub;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NSTEP = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    serial_addsub #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic on the operands, independent of digit slicing.
    function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic ms,
                                  output logic [15:0] s, output logic c, output logic o);
        int ua = int'(ma);
        int ub = int'(mb);
        int sa = int'($signed(ma));
        int sb = int'($signed(mb));
        int r;
        if (!ms) begin
            c = (ua + ub) > 65535;
            r = sa + sb;
            s = 16'(ua + ub);
        end else begin
            c = ua >= ub;
            r = sa - sb;
            s = 16'(ua - ub);
        end
        o = (r > 32767) || (r < -32768);
`ifdef SERIAL_ADDSUB_SAT_EN
        if (o) s = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, presents one operand pair, returns the cycle of the accepting edge.
    task automatic accept(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                          output int acc_cyc);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("accept_timeout", {31'b0, in_ready}, 32'd1);
        a = ta;
        b = tb;
        sub = ts;
        in_valid = 1'b1;
        tick();
        acc_cyc = cyc;
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_directed(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                                input logic ts, input logic [15:0] es, input logic ec,
                                input logic eo);
        int acc, lat;
        accept(ta, tb, ts, acc);
        wait_done(lat);
        check({tag, "_lat"}, lat, NSTEP);
        check({tag, "_sum"}, {16'b0, sum}, {16'b0, es});
        check({tag, "_cout"}, {31'b0, cout}, {31'b0, ec});
        check({tag, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
    endtask

    logic [15:0] held_sum;
    logic        held_cout, held_ovf;
    logic [15:0] ms;
    logic        mc, mo;
    logic [15:0] ra, rb;
    logic        rs;
    int          acc_prev, acc_now, lat;
    int          spacing_bad;

    initial begin
        // Reset: in_valid asserted throughout must not cause a transfer.
        in_valid = 1'b1;
        a = 16'h1111;
        b = 16'h2222;
        tick();
        tick();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_sum", {16'b0, sum}, 32'd0);
        check("rst_flags", {30'b0, cout, ovf}, 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_idle", {30'b0, in_ready, out_valid}, 32'd2);

        run_directed("add_1234_0fff", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        run_directed("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef SERIAL_ADDSUB_SAT_EN
        run_directed("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_directed("sub_8000_0001", 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
        run_directed("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_directed("sub_8000_0001", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif
        run_directed("sub_0005_0007", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        tick();

        // Backpressure: hold DONE for 10 cycles while offering new operands.
        out_ready = 1'b0;
        run_directed("bp_first", 16'h4321, 16'h1111, 1'b1, 16'h3210, 1'b1, 1'b0);
        held_sum = sum;
        held_cout = cout;
        held_ovf = ovf;
        in_valid = 1'b1;
        a = 16'hAAAA;
        b = 16'h5555;
        sub = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_sum_stable", {14'b0, sum, cout, ovf}, {14'b0, held_sum, held_cout, held_ovf});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release", {30'b0, in_ready, out_valid}, 32'd2);
        run_directed("bp_next", 16'h0100, 16'h0023, 1'b0, 16'h0123, 1'b0, 1'b0);
        tick();

        // Reset mid-RUN discards the operation.
        accept(16'h7777, 16'h1111, 1'b0, acc_now);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_sum", {16'b0, sum}, 32'd0);
        check("midrst_flags", {30'b0, cout, ovf}, 32'd0);
        tick();
        tick();
        check("midrst_no_pulse", {31'b0, out_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("midrst_idle", {30'b0, in_ready, out_valid}, 32'd2);
        run_directed("after_rst_add", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Back-to-back random operations with out_ready held high.
        spacing_bad = 0;
        acc_prev = -1;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            if (i % 8 == 0) rb = ra ^ 16'($urandom_range(0, 1));
            accept(ra, rb, rs, acc_now);
            if (acc_prev >= 0 && (acc_now - acc_prev) != NSTEP + 2) spacing_bad++;
            acc_prev = acc_now;
            wait_done(lat);
            model(ra, rb, rs, ms, mc, mo);
            if (lat != NSTEP) check("rnd_lat", lat, NSTEP);
            check("rnd_result", {14'b0, sum, cout, ovf}, {14'b0, ms, mc, mo});
        end
        check("rnd_spacing_errors", spacing_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
